// File: rtl/parc_core_reorder_buffer_pkg.sv
// Shared PARC constants: ROB geometry, functional-unit and bypass-mux encodings.
// The scoreboard and the reorder buffer both import this so their encodings agree.
package parc_core_reorder_buffer_pkg;

    localparam int unsigned ROB_ENTRIES = 16;
    localparam int unsigned ROB_SLOT_W  = 4;
    localparam int unsigned ROB_DATA_W  = 32;
    localparam int unsigned ROB_REG_W   = 5;

    typedef enum logic [1:0] {
        FUNC_UNIT_ALU = 2'd0,
        FUNC_UNIT_MUL = 2'd1,
        FUNC_UNIT_MEM = 2'd2,
        FUNC_UNIT_CSR = 2'd3
    } func_unit_e;

    // Operand bypass mux select; ROB bypass must stay at 5 to match the scoreboard.
    typedef enum logic [2:0] {
        BYP_RF  = 3'd0,
        BYP_X0  = 3'd1,
        BYP_X1  = 3'd2,
        BYP_X2  = 3'd3,
        BYP_W   = 3'd4,
        BYP_ROB = 3'd5
    } byp_sel_e;

endpackage

// File: rtl/parc_core_reorder_buffer_ptr.sv
// Wrapping slot pointer: increments modulo 2**W when enabled, clears on reset.
module parc_core_reorder_buffer_ptr #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/parc_core_reorder_buffer.sv
// In-order retirement controller for the PARC pipeline: allocates slots at issue,
// records writeback results, retires head-first into the register file.
module parc_core_reorder_buffer
    import parc_core_reorder_buffer_pkg::*;
#(
    parameter int unsigned ENTRIES = ROB_ENTRIES,
    parameter int unsigned SLOT_W  = ROB_SLOT_W,
    parameter int unsigned DATA_W  = ROB_DATA_W,
    parameter int unsigned REG_W   = ROB_REG_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              rob_alloc_req_val,
    output logic              rob_alloc_req_rdy,
    input  logic [REG_W-1:0]  rob_alloc_req_preg,
    output logic [SLOT_W-1:0] rob_alloc_resp_slot,

    input  logic              rob_fill_val,
    input  logic [SLOT_W-1:0] rob_fill_slot,
    input  logic [DATA_W-1:0] rob_fill_data,

    output logic              rob_commit_wen,
    output logic [SLOT_W-1:0] rob_commit_slot,
    output logic [REG_W-1:0]  rob_commit_rf_waddr,
    output logic [DATA_W-1:0] rob_commit_rf_wdata,

    input  logic [SLOT_W-1:0] src0_byp_slot,
    output logic [DATA_W-1:0] src0_byp_data,
    input  logic [SLOT_W-1:0] src1_byp_slot,
    output logic [DATA_W-1:0] src1_byp_data
);

    localparam logic [SLOT_W:0] FULL_COUNT = (SLOT_W+1)'(ENTRIES);

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] pending_q;
    logic [REG_W-1:0]   preg_q [ENTRIES];
    logic [DATA_W-1:0]  data_q [ENTRIES];

    logic [SLOT_W-1:0]  head;
    logic [SLOT_W-1:0]  tail;
    logic [SLOT_W:0]    count_q;

    logic               alloc_fire;
    logic               commit_fire;
    logic               fill_fire;

    parc_core_reorder_buffer_ptr #(.W(SLOT_W)) head_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (commit_fire),
        .ptr   (head)
    );

    parc_core_reorder_buffer_ptr #(.W(SLOT_W)) tail_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (alloc_fire),
        .ptr   (tail)
    );

    // Readiness looks only at the registered count, so a full ROB refuses an
    // allocation even when the head retires in the same cycle.
    always_comb begin
        rob_alloc_req_rdy   = !reset && (count_q != FULL_COUNT);
        rob_alloc_resp_slot = tail;
        alloc_fire          = rob_alloc_req_val && rob_alloc_req_rdy;

        commit_fire         = !reset && valid_q[head] && !pending_q[head];
        rob_commit_wen      = commit_fire;
        rob_commit_slot     = head;
        rob_commit_rf_waddr = preg_q[head];
        rob_commit_rf_wdata = data_q[head];

        fill_fire           = rob_fill_val && valid_q[rob_fill_slot];
    end

    assign src0_byp_data = data_q[src0_byp_slot];
    assign src1_byp_data = data_q[src1_byp_slot];

    // Alloc (tail), fill and commit (head) touch distinct slots whenever all three
    // fire: tail==head with a live head only happens when full, which blocks alloc.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            pending_q <= '0;
        end else begin
            if (fill_fire) begin
                pending_q[rob_fill_slot] <= 1'b0;
            end
            if (commit_fire) begin
                valid_q[head] <= 1'b0;
            end
            if (alloc_fire) begin
                valid_q[tail]   <= 1'b1;
                pending_q[tail] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_fire) begin
            data_q[rob_fill_slot] <= rob_fill_data;
        end
        if (alloc_fire) begin
            preg_q[tail] <= rob_alloc_req_preg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            case ({alloc_fire, commit_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_parc_core_reorder_buffer.sv
// Directed bench for the reorder buffer: alloc/fill/commit ordering, full/wrap,
// simultaneous alloc+commit, bypass reads and mid-operation reset.
module tb_parc_core_reorder_buffer;

    logic        clk;
    logic        reset;
    logic        rob_alloc_req_val;
    logic        rob_alloc_req_rdy;
    logic [4:0]  rob_alloc_req_preg;
    logic [3:0]  rob_alloc_resp_slot;
    logic        rob_fill_val;
    logic [3:0]  rob_fill_slot;
    logic [31:0] rob_fill_data;
    logic        rob_commit_wen;
    logic [3:0]  rob_commit_slot;
    logic [4:0]  rob_commit_rf_waddr;
    logic [31:0] rob_commit_rf_wdata;
    logic [3:0]  src0_byp_slot;
    logic [31:0] src0_byp_data;
    logic [3:0]  src1_byp_slot;
    logic [31:0] src1_byp_data;

    int total = 0;
    int bad   = 0;

    parc_core_reorder_buffer #(
        .ENTRIES (16),
        .SLOT_W  (4),
        .DATA_W  (32),
        .REG_W   (5)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .rob_alloc_req_val   (rob_alloc_req_val),
        .rob_alloc_req_rdy   (rob_alloc_req_rdy),
        .rob_alloc_req_preg  (rob_alloc_req_preg),
        .rob_alloc_resp_slot (rob_alloc_resp_slot),
        .rob_fill_val        (rob_fill_val),
        .rob_fill_slot       (rob_fill_slot),
        .rob_fill_data       (rob_fill_data),
        .rob_commit_wen      (rob_commit_wen),
        .rob_commit_slot     (rob_commit_slot),
        .rob_commit_rf_waddr (rob_commit_rf_waddr),
        .rob_commit_rf_wdata (rob_commit_rf_wdata),
        .src0_byp_slot       (src0_byp_slot),
        .src0_byp_data       (src0_byp_data),
        .src1_byp_slot       (src1_byp_slot),
        .src1_byp_data       (src1_byp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rob_alloc_req_val  = 1'b0;
        rob_alloc_req_preg = '0;
        rob_fill_val       = 1'b0;
        rob_fill_slot      = '0;
        rob_fill_data      = '0;
    endtask

    task automatic apply_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        int n;
        src0_byp_slot = '0;
        src1_byp_slot = '0;
        idle();

        // Reset values, including forced outputs while reset is high
        reset = 1'b1;
        tick();
        tick();
        rob_alloc_req_val = 1'b1;
        #1;
        chk("rst_rdy", rob_alloc_req_rdy, 0);
        chk("rst_wen", rob_commit_wen, 0);
        rob_alloc_req_val = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_rdy", rob_alloc_req_rdy, 1);
        chk("post_rst_slot", rob_alloc_resp_slot, 0);
        chk("post_rst_wen", rob_commit_wen, 0);

        // Single alloc, fill, commit
        rob_alloc_req_val  = 1'b1;
        rob_alloc_req_preg = 5'd3;
        #1;
        chk("t1_slot", rob_alloc_resp_slot, 0);
        tick();
        idle();
        rob_fill_val  = 1'b1;
        rob_fill_slot = 4'd0;
        rob_fill_data = 32'hDEADBEEF;
        #1;
        chk("t1_pending_wen", rob_commit_wen, 0);
        tick();
        idle();
        #1;
        chk("t1_wen", rob_commit_wen, 1);
        chk("t1_waddr", rob_commit_rf_waddr, 3);
        chk("t1_wdata", rob_commit_rf_wdata, 32'hDEADBEEF);
        chk("t1_cslot", rob_commit_slot, 0);
        tick();
        chk("t1_wen_after", rob_commit_wen, 0);
        chk("t1_tail", rob_alloc_resp_slot, 1);

        // Out-of-order fills retire in allocation order
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            rob_alloc_req_val  = 1'b1;
            rob_alloc_req_preg = 5'(4 + i);
            #1;
            chk("t2_slot", rob_alloc_resp_slot, 32'(i));
            tick();
        end
        idle();
        rob_fill_val  = 1'b1;
        rob_fill_slot = 4'd2;
        rob_fill_data = 32'hA2;
        tick();
        chk("t2_hold_wen", rob_commit_wen, 0);
        rob_fill_slot = 4'd0;
        rob_fill_data = 32'hA0;
        tick();
        rob_fill_slot = 4'd1;
        rob_fill_data = 32'hA1;
        #1;
        chk("t2_c0_wen", rob_commit_wen, 1);
        chk("t2_c0_slot", rob_commit_slot, 0);
        chk("t2_c0_waddr", rob_commit_rf_waddr, 4);
        chk("t2_c0_wdata", rob_commit_rf_wdata, 32'hA0);
        tick();
        idle();
        #1;
        chk("t2_c1_wen", rob_commit_wen, 1);
        chk("t2_c1_slot", rob_commit_slot, 1);
        chk("t2_c1_waddr", rob_commit_rf_waddr, 5);
        chk("t2_c1_wdata", rob_commit_rf_wdata, 32'hA1);
        tick();
        chk("t2_c2_wen", rob_commit_wen, 1);
        chk("t2_c2_slot", rob_commit_slot, 2);
        chk("t2_c2_waddr", rob_commit_rf_waddr, 6);
        chk("t2_c2_wdata", rob_commit_rf_wdata, 32'hA2);
        tick();
        chk("t2_empty_wen", rob_commit_wen, 0);

        // Fill to full, refused alloc on a commit cycle, wrap of tail
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            rob_alloc_req_val  = 1'b1;
            rob_alloc_req_preg = 5'(i);
            #1;
            chk("t3_slot", rob_alloc_resp_slot, 32'(i));
            tick();
        end
        #1;
        chk("t3_full_rdy", rob_alloc_req_rdy, 0);
        chk("t3_full_tail", rob_alloc_resp_slot, 0);
        tick();
        chk("t3_refused_rdy", rob_alloc_req_rdy, 0);
        chk("t3_full_wen", rob_commit_wen, 0);
        rob_fill_val  = 1'b1;
        rob_fill_slot = 4'd0;
        rob_fill_data = 32'h100;
        tick();
        rob_fill_val = 1'b0;
        #1;
        chk("t3_commit_wen", rob_commit_wen, 1);
        chk("t3_commit_slot", rob_commit_slot, 0);
        chk("t3_commit_wdata", rob_commit_rf_wdata, 32'h100);
        chk("t3_commit_waddr", rob_commit_rf_waddr, 0);
        chk("t3_commit_rdy", rob_alloc_req_rdy, 0);
        tick();
        idle();
        #1;
        chk("t3_after_rdy", rob_alloc_req_rdy, 1);
        chk("t3_after_tail", rob_alloc_resp_slot, 0);
        chk("t3_after_head", rob_commit_slot, 1);
        chk("t3_after_wen", rob_commit_wen, 0);

        // count=8 with simultaneous alloc and commit keeps count, moves both pointers
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            rob_alloc_req_val  = 1'b1;
            rob_alloc_req_preg = 5'(i + 8);
            tick();
        end
        idle();
        rob_fill_val  = 1'b1;
        rob_fill_slot = 4'd0;
        rob_fill_data = 32'h55;
        tick();
        idle();
        rob_alloc_req_val  = 1'b1;
        rob_alloc_req_preg = 5'd20;
        #1;
        chk("t4_both_wen", rob_commit_wen, 1);
        chk("t4_both_tail", rob_alloc_resp_slot, 8);
        chk("t4_both_head", rob_commit_slot, 0);
        tick();
        rob_alloc_req_val = 1'b0;
        #1;
        chk("t4_tail_adv", rob_alloc_resp_slot, 9);
        chk("t4_head_adv", rob_commit_slot, 1);
        chk("t4_wen_after", rob_commit_wen, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            rob_alloc_req_val = 1'b1;
            #1;
            if (!rob_alloc_req_rdy) break;
            n++;
            tick();
        end
        idle();
        chk("t4_free_slots", 32'(n), 8);

        // Bypass reads: old data during the fill cycle, new data afterwards
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            rob_alloc_req_val  = 1'b1;
            rob_alloc_req_preg = 5'(i + 1);
            tick();
        end
        idle();
        src0_byp_slot = 4'd5;
        src1_byp_slot = 4'd5;
        rob_fill_val  = 1'b1;
        rob_fill_slot = 4'd5;
        rob_fill_data = 32'h0BADF00D;
        tick();
        rob_fill_data = 32'h12345678;
        #1;
        chk("t5_byp0_old", src0_byp_data, 32'h0BADF00D);
        chk("t5_byp1_old", src1_byp_data, 32'h0BADF00D);
        tick();
        idle();
        #1;
        chk("t5_byp0_new", src0_byp_data, 32'h12345678);
        chk("t5_byp1_new", src1_byp_data, 32'h12345678);
        chk("t5_no_commit", rob_commit_wen, 0);

        // Reset mid-operation discards entries; stale fills are ignored
        reset = 1'b1;
        rob_fill_val  = 1'b1;
        rob_fill_slot = 4'd0;
        rob_fill_data = 32'h77;
        #1;
        chk("t6_rst_wen", rob_commit_wen, 0);
        chk("t6_rst_rdy", rob_alloc_req_rdy, 0);
        tick();
        reset = 1'b0;
        rob_fill_val = 1'b0;
        #1;
        chk("t6_wen", rob_commit_wen, 0);
        chk("t6_slot", rob_alloc_resp_slot, 0);
        chk("t6_head", rob_commit_slot, 0);
        chk("t6_rdy", rob_alloc_req_rdy, 1);
        rob_fill_val  = 1'b1;
        rob_fill_slot = 4'd0;
        rob_fill_data = 32'h99;
        tick();
        rob_fill_slot = 4'd1;
        tick();
        idle();
        #1;
        chk("t6_stale_wen", rob_commit_wen, 0);
        rob_alloc_req_val  = 1'b1;
        rob_alloc_req_preg = 5'd7;
        tick();
        idle();
        #1;
        chk("t6_new_pending", rob_commit_wen, 0);
        chk("t6_new_tail", rob_alloc_resp_slot, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parc_core_reorder_buffer.md
Name: parc_core_reorder_buffer

Overview:
In-order retirement controller for the 5-stage PARC pipeline.
- Allocates one ROB slot per issued instruction that writes a register.
- Records writeback completion and the result data for each slot.
- Retires slots strictly in allocation order and drives register-file commit.
- Supplies the slot/commit handshake used by the scoreboard (alloc slot, commit slot, commit wen) and the ROB bypass data read for byp mux select 5.

Parameters:
ENTRIES, 16, number of ROB slots; power of two.
SLOT_W, 4, slot index width; log2(ENTRIES).
DATA_W, 32, result data width.
REG_W, 5, architectural register index width.

Ports:
clk  input  1  clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
rob_alloc_req_val  input  1  issue stage requests a slot (accepted instruction with dst_en)
rob_alloc_req_rdy  output  1  a slot is available (count < ENTRIES)
rob_alloc_req_preg  input  REG_W  destination register of the allocating instruction
rob_alloc_resp_slot  output  SLOT_W  slot granted; equals tail pointer; valid whenever rdy=1
rob_fill_val  input  1  writeback stage delivers a result
rob_fill_slot  input  SLOT_W  slot being filled
rob_fill_data  input  DATA_W  result value
rob_commit_wen  output  1  head slot retires this cycle; register-file write enable
rob_commit_slot  output  SLOT_W  slot retiring (head pointer)
rob_commit_rf_waddr  output  REG_W  preg of head slot
rob_commit_rf_wdata  output  DATA_W  data of head slot
src0_byp_slot  input  SLOT_W  bypass read slot, operand 0
src0_byp_data  output  DATA_W  data[src0_byp_slot], combinational
src1_byp_slot  input  SLOT_W  bypass read slot, operand 1
src1_byp_data  output  DATA_W  data[src1_byp_slot], combinational

Behaviour:
- State per entry: valid, pending, preg, data. Global state: head, tail (SLOT_W each, wrap modulo ENTRIES) and count (SLOT_W+1 bits, 0..ENTRIES).
- Reset:
  - All valid and pending bits clear; head = tail = 0; count = 0.
  - While reset is high, rdy and commit_wen are forced to 0.
  - The first cycle after reset has rdy=1 and resp_slot=0.
  - Reset mid-operation discards all entries with no commit.
  - preg and data need not be reset.
- Alloc:
  - Fires when val && rdy.
  - Next edge: valid[tail]=1, pending[tail]=1, preg[tail]=req_preg, tail++.
  - Zero-latency grant: the slot is visible combinationally in the same cycle, so the scoreboard can latch it.
  - rdy is computed from the current count only. When full, alloc is refused even if a commit occurs that cycle.
- Fill:
  - On fill_val: if valid[fill_slot], then pending=0 and data=fill_data on the next edge.
  - Fill to an invalid slot is ignored.
  - Fill to an already-filled slot overwrites data; this is not expected from the pipeline.
- Commit:
  - commit_wen = valid[head] && !pending[head], combinational from registered state.
  - When asserted: waddr, wdata and slot come from the head entry; next edge clears valid[head] and does head++.
  - At most one commit per cycle.
  - A fill and a commit cannot both complete on the same slot in one cycle: a fill to the head slot makes it committable on the following cycle.
  - preg 0 commits normally (wen=1); the register file discards writes to r0.
- Count update:
  - alloc only: count+1.
  - commit only: count-1.
  - both: unchanged.
  - Full is count==ENTRIES; empty is count==0. With head==tail, count disambiguates full from empty.
- Bypass reads:
  - Pure combinational array reads, with no forwarding from a same-cycle fill.
  - The scoreboard selects ROB bypass only after writeback has completed (latency 0).
  - The read is valid until that slot commits.
- Simultaneous alloc + fill + commit on three distinct slots in one cycle is legal and all three take effect.

Decomposition:
- Shared PARC include holds:
  - ROB depth/width constants (ENTRIES, SLOT_W).
  - The `FUNC_UNIT_*` and byp-mux-select encodings, including ROB bypass = 5, so the scoreboard and this block agree.
- No sub-module is required. Optionally, a small parc_rob_ptr (wrapping increment register) can be instantiated for head and tail.

Test Plan:
- Reset, then alloc preg=3 -> resp_slot=0; fill slot0 data=0xDEADBEEF -> the following cycle commit_wen=1, waddr=3, wdata=0xDEADBEEF, slot=0.
- Allocate slots 0,1,2 (pregs 4,5,6), fill in order 2,0,1 -> commits occur strictly as slot0, slot1, slot2, with no commit while slot0 is pending.
- Allocate 16 with no fills -> rdy=0 at count 16; alloc_val ignored. Fill slot0 -> commit next cycle; rdy=1 the cycle after, resp_slot=0 (wrap).
- Full ROB with a same-cycle alloc request and commit -> alloc refused; count goes 16->15. With count=8, simultaneous alloc + commit -> count stays 8; head and tail both advance.
- Fill slot 5 with 0x12345678, src0_byp_slot=5 and src1_byp_slot=5 -> both bypass outputs read 0x12345678 the next cycle. In the fill cycle itself, outputs show the old data.
- Assert reset while 6 entries are pending -> the next cycle has count=0, commit_wen=0, resp_slot=0. Stale fills to old slots are ignored.
